// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage issue logic and muldiv_unit.
// The master drives operations and MTHI/MTLO writes; the slave returns busy/done and HI/LO.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit (one bit per cycle) with HI/LO and MTHI/MTLO writes.
// Define MULDIV_FAST_MUL_EN to compute products in a single cycle; divides stay iterative.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Shared accumulator: {acc_hi, acc_lo} is the product for multiply,
  // {remainder, dividend/quotient shift register} for divide.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             launch;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  // Signed ops run on magnitudes; the sign is restored in StFix.
  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.src_a[WIDTH-1];
  assign b_neg     = is_signed & bus.src_b[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
  assign b_mag     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
  assign launch    = (state_q == StIdle) & bus.start & ~bus.flush;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign prod_mag  = {acc_hi_q, acc_lo_q};
  assign prod_res  = neg_lo_q ? (~prod_mag + 1'b1) : prod_mag;
  // A zero divisor leaves |dividend| as the remainder, so only the quotient needs overriding.
  assign quo_res   = dz_q ? {WIDTH{1'b1}} : (neg_lo_q ? (~acc_lo_q + 1'b1) : acc_lo_q);
  assign rem_res   = neg_hi_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (launch) begin
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          opb_d    = b_mag;
          is_div_d = bus.op[1];
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = bus.op[1] & (bus.src_b == '0);
          cnt_d    = '0;
          state_d  = StRun;
`ifdef MULDIV_FAST_MUL_EN
          if (!bus.op[1]) begin
            acc_hi_d = fast_prod[2*WIDTH-1:WIDTH];
            acc_lo_d = fast_prod[WIDTH-1:0];
            state_d  = StFix;
          end
`endif
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end

      StRun: begin
        if (is_div_q) begin
          // Restoring step: keep the trial difference only when it did not borrow.
          if (!div_diff[WIDTH]) begin
            acc_hi_d = div_diff[WIDTH-1:0];
          end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
          end
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) state_d = StFix;
      end

      StFix: begin
        if (is_div_q) begin
          lo_d = quo_res;
          hi_d = rem_res;
        end else begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Abort in flight: drop the result; idle MTHI/MTLO writes still land.
    if (bus.flush && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected HI/LO, a monitor checks on done.
module tb_muldiv_unit;
  localparam int unsigned WIDTH = 32;
  localparam int LAT = WIDTH + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = LAT;
`endif

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] op_id = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap actual=1 expected=0");
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 hi=%h lo=%h", bus.hi, bus.lo);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("op%0d_hi", mon_e.id), bus.hi, mon_e.hi);
          check($sformatf("op%0d_lo", mon_e.id), bus.lo, mon_e.lo);
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge with start released.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit expect_done);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    if (expect_done) begin
      e.hi = exp_hi;
      e.lo = exp_lo;
      e.id = op_id;
      sb.push_back(e);
    end
    op_id++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_a = $urandom();
    bus.src_b = $urandom();
  endtask

  // Entered at the negedge of cycle 1 (start cycle is 0); exits at the done negedge.
  task automatic wait_done(input int exp_lat, input bit chk_lat);
    int cyc = 1;
    int busy_cnt = 0;
    while (!bus.done && cyc < 200) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d expected=%0d", cyc, exp_lat);
    end else if (chk_lat) begin
      check("latency", cyc, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat - 1);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int lat);
    issue(op, a, b, exp_hi, exp_lo, 1'b1);
    wait_done(lat, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);

    do_op(OpMult,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT);
    do_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT);
    do_op(OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT);
    do_op(OpMult,  32'h80000000, 32'h1,        32'hFFFFFFFF, 32'h80000000, MUL_LAT);
    do_op(OpDivu,  32'd100,      32'd7,        32'd2,        32'd14,       LAT);
    do_op(OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, LAT);
    do_op(OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, LAT);
    do_op(OpDivu,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, LAT);
    do_op(OpDiv,   32'hFFFFFFF6, 32'd0,        32'hFFFFFFF6, 32'hFFFFFFFF, LAT);
    do_op(OpDiv,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, LAT);

    // Flush at iteration 10: no done, HI/LO keep the DIV 7/-2 result.
    issue(OpDivu, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_hi", bus.hi, 32'd1);
    check("flush_lo", bus.lo, 32'hFFFFFFFD);

    // Flush together with start in idle: nothing launches.
    bus.flush = 1'b1;
    issue(OpMultu, 32'd3, 32'd3, 32'h0, 32'h0, 1'b0);
    bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    check("flush_start_busy_later", 32'(bus.busy), 32'd0);

    // MTHI/MTLO while busy are ignored.
    issue(OpMultu, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    wait_done(MUL_LAT, 1'b0);
    @(negedge clk);

    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_idle_hi", bus.hi, 32'h1234);
    check("mthi_idle_lo", bus.lo, 32'd15);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthilo_hi", bus.hi, 32'hABCD);
    check("mthilo_lo", bus.lo, 32'hABCD);

    // Back-to-back: second start lands in the done cycle of the first.
    issue(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(LAT, 1'b1);
    issue(OpMult, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
    wait_done(MUL_LAT, 1'b1);
    @(negedge clk);

    // Reset mid-divide clears everything.
    issue(OpDivu, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_hi", bus.hi, 32'h0);
    check("rst_mid_lo", bus.lo, 32'h0);
    repeat (40) @(negedge clk);
    check("rst_mid_hi_later", bus.hi, 32'h0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
